user_wb_interconnect: RTL and testbench



---
 rtl/user_wb_interconnect.sv | 150 +++++++++++++++
 tb/tb_user_wb_interconnect.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_wb_interconnect.sv
// rtl/user_wb_interconnect.sv - Wishbone classic decoder for the user project area with an ack watchdog
// One outstanding transaction; hung or unmapped accesses complete with ERR_DATA and an irq pulse.
module user_wb_interconnect #(
   parameter int          NSLV     = 2,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_n_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   output logic [NSLV:0]            s_cyc_o,
   output logic                     s_stb_o,
   output logic                     s_we_o,
   output logic [3:0]               s_sel_o,
   output logic [31:0]              s_adr_o,
   output logic [31:0]              s_dat_o,
   input  logic [NSLV:0]            s_ack_i,
   input  logic [32*(NSLV+1)-1:0]   s_dat_i,
   output logic [15:0]              err_count_o,
   output logic                     timeout_irq_o
);

   typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [NSLV:0] cyc_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          ack_d, irq_d;
   logic [31:0]   dat_d;
   logic [15:0]   errc_d;
   logic [NSLV:0] dec_sel;
   logic          dec_hit;
   logic          sel_ack;
   logic [31:0]   sel_dat;
   logic          active;

   assign active = (state_q == ACTIVE);

   // Pass-through is forced to zero outside ACTIVE so the slaves see a quiet bus between transactions
   assign s_stb_o = active & wbs_stb_i;
   assign s_we_o  = active & wbs_we_i;
   assign s_sel_o = {4{active}} & wbs_sel_i;
   assign s_adr_o = {32{active}} & wbs_adr_i;
   assign s_dat_o = {32{active}} & wbs_dat_i;

   always_comb begin
      dec_sel = '0;
      if (wbs_adr_i[31:3] == 29'h601_FFFF) begin
         dec_sel[NSLV] = 1'b1;
      end else begin
         for (int k = 0; k < NSLV; k++) begin
            if (wbs_adr_i[19:16] == 4'(k)) dec_sel[k] = 1'b1;
         end
      end
   end

   assign dec_hit = |dec_sel;

   // s_cyc_o is one-hot, so masking with it both selects and ignores unselected acks
   assign sel_ack = |(s_ack_i & s_cyc_o);

   always_comb begin
      sel_dat = '0;
      for (int k = 0; k <= NSLV; k++) begin
         if (s_cyc_o[k]) sel_dat = s_dat_i[32*k +: 32];
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = s_cyc_o;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      irq_d   = 1'b0;
      dat_d   = wbs_dat_o;
      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               if (dec_hit) begin
                  cyc_d   = dec_sel;
                  cnt_d   = '0;
                  state_d = ACTIVE;
               end else begin
                  ack_d   = 1'b1;
                  irq_d   = 1'b1;
                  dat_d   = ERR_DATA;
                  state_d = RESP;
               end
            end
         end
         ACTIVE: begin
            cnt_d = cnt_q + 16'd1;
            if (!wbs_cyc_i) begin
               cyc_d   = '0;
               state_d = IDLE;
            end else if (sel_ack) begin
               cyc_d   = '0;
               ack_d   = 1'b1;
               dat_d   = sel_dat;
               state_d = RESP;
            end else if (cnt_q == TO_LAST) begin
               cyc_d   = '0;
               ack_d   = 1'b1;
               irq_d   = 1'b1;
               dat_d   = ERR_DATA;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            cyc_d   = '0;
            state_d = IDLE;
         end
      endcase
      errc_d = (irq_d && err_count_o != 16'hFFFF) ? err_count_o + 16'd1 : err_count_o;
   end

   // Response outputs load on the edge entering RESP so they are visible during the RESP cycle
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q       <= IDLE;
         s_cyc_o       <= '0;
         cnt_q         <= '0;
         wbs_ack_o     <= 1'b0;
         wbs_dat_o     <= '0;
         timeout_irq_o <= 1'b0;
         err_count_o   <= '0;
      end else begin
         state_q       <= state_d;
         s_cyc_o       <= cyc_d;
         cnt_q         <= cnt_d;
         wbs_ack_o     <= ack_d;
         wbs_dat_o     <= dat_d;
         timeout_irq_o <= irq_d;
         err_count_o   <= errc_d;
      end
   end

endmodule

// File: tb/tb_user_wb_interconnect.sv
// tb/tb_user_wb_interconnect.sv - scoreboard bench for user_wb_interconnect
module tb_user_wb_interconnect;

   localparam int          NSLV = 2;
   localparam int          TMO  = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0] sel = '0;
   logic [31:0] adr = '0, wdat = '0;
   logic ack;
   logic [31:0] rdat;
   logic [NSLV:0] s_cyc;
   logic s_stb, s_we;
   logic [3:0] s_sel;
   logic [31:0] s_adr, s_wdat;
   logic [NSLV:0] s_ack = '0;
   logic [32*(NSLV+1)-1:0] s_rdat = '0;
   logic [15:0] err_cnt;
   logic irq;

   int total = 0;
   int bad = 0;
   int cur_lat = 1;
   bit spur_all = 1'b0;
   int model_err = 0;

   typedef struct {logic [31:0] dat; bit err; bit wr;} resp_t;
   typedef struct {logic [NSLV:0] oh; int len;} cyc_t;
   resp_t resp_q[$];
   cyc_t  cyc_q[$];

   always #5 clk = ~clk;

   user_wb_interconnect #(.NSLV(NSLV), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
      .err_count_o(err_cnt), .timeout_irq_o(irq)
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Address map: debug pair at the top, then windows selected by bits 19:16
   function automatic int target(input logic [31:0] a);
      if (a[31:3] == 29'h601FFFF) return NSLV;
      if (int'(a[19:16]) < NSLV) return int'(a[19:16]);
      return -1;
   endfunction

   task automatic do_txn(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input logic [3:0] s, input int lat, input logic [31:0] rd);
      int t, k, explen;
      bit err;
      logic [NSLV:0] oh;
      t = target(a);
      @(negedge clk);
      for (int i = 0; i <= NSLV; i++) s_rdat[32*i +: 32] = $urandom;
      if (t >= 0) s_rdat[32*t +: 32] = rd;
      cur_lat = lat;
      adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
      if (t < 0) begin
         err = 1'b1;
         explen = 0;
      end else begin
         err = (lat > TMO);
         explen = err ? TMO : lat;
         oh = '0;
         oh[t] = 1'b1;
         cyc_q.push_back('{oh, explen});
      end
      resp_q.push_back('{err ? ERRD : rd, err, w});
      if (err && model_err < 65535) model_err++;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ack && k < 40);
      check("ack_latency", k, (t < 0) ? 1 : explen + 1);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("err_count", err_cnt, model_err);
   endtask

   // Response monitor
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ack) begin
            if (resp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_ack: got ack=1 expected no ack");
            end else begin
               e = resp_q.pop_front();
               if (!(e.wr && e.err)) check("read_data", rdat, e.dat);
               check("irq_flag", irq, e.err);
            end
         end else if (rst_n && irq) begin
            total++; bad++;
            $display("FAIL stray_irq: got irq=1 expected 0 without ack");
         end
      end
   end

   // Slave model and s_cyc monitor
   initial begin
      int run;
      logic [NSLV:0] last;
      logic [NSLV:0] rnd;
      cyc_t c;
      run = 0;
      last = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run = 0;
         end else if (s_cyc != '0) begin
            if (run == 0) begin
               last = s_cyc;
               check("pass_through", {s_stb, s_we, s_sel, s_adr, s_wdat}, {1'b1, we, sel, adr, wdat});
            end
            run++;
         end else if (run != 0) begin
            if (cyc_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_cyc: got %0h len %0d expected none", last, run);
            end else begin
               c = cyc_q.pop_front();
               check("cyc_onehot", last, c.oh);
               check("cyc_len", run, c.len);
            end
            run = 0;
         end
         s_ack = (s_cyc != '0 && run == cur_lat) ? s_cyc : '0;
         rnd = $urandom;
         if (spur_all) s_ack = s_ack | ~s_cyc;
         else if ($urandom_range(0, 3) == 0) s_ack = s_ack | (rnd & ~s_cyc);
      end
   end

   initial begin
      logic [31:0] a;
      int kind;
      int t;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {ack, rdat, s_cyc, err_cnt, irq, s_stb, s_we, s_sel, s_adr, s_wdat}, 128'd0);
      rst_n = 1'b1;

      do_txn(32'h3000_0004, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678);
      spur_all = 1'b1;
      do_txn(32'h300F_FFFC, 1'b1, 32'hA5A5_A5A5, 4'hF, 2, 32'h0BAD_0001);
      spur_all = 1'b0;
      do_txn(32'h3005_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0);
      do_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, 99, 32'h0);
      do_txn(32'h3001_0020, 1'b0, 32'h0, 4'h3, 2, 32'hCAFE_F00D);
      do_txn(32'h3001_0000, 1'b0, 32'h0, 4'hF, TMO, 32'h5A5A_0004);
      do_txn(32'h300F_FFF8, 1'b0, 32'h0, 4'h1, 1, 32'h0000_D0D0);

      repeat (150) begin
         kind = $urandom_range(0, 3);
         a = $urandom;
         a[1:0] = 2'b00;
         case (kind)
            0: a[19:16] = 4'h0;
            1: a[19:16] = 4'h1;
            2: a = ($urandom_range(0, 1) == 1) ? 32'h300F_FFF8 : 32'h300F_FFFC;
            default: a[19:16] = 4'($urandom_range(2, 14));
         endcase
         do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(1, 6), $urandom);
      end

      // master abort in the second ACTIVE cycle
      @(negedge clk);
      cur_lat = 99;
      adr = 32'h3000_0100; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      cyc_q.push_back('{3'b001, 2});
      @(negedge clk);
      @(negedge clk);
      #2 cyc = 1'b0;
      repeat (3) @(negedge clk);
      stb = 1'b0;
      check("abort_count", err_cnt, model_err);

      // saturation of the error counter
      @(negedge clk);
      force dut.err_count_o = 16'hFFFE;
      @(negedge clk);
      release dut.err_count_o;
      model_err = 16'hFFFE;
      check("forced_count", err_cnt, 16'hFFFE);
      do_txn(32'h3007_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0);
      do_txn(32'h3008_0000, 1'b1, 32'h1, 4'hF, 1, 32'h0);

      // reset in the middle of ACTIVE
      @(negedge clk);
      cur_lat = 99;
      adr = 32'h3001_0040; we = 1'b1; wdat = 32'h1357_9BDF; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs", {ack, rdat, s_cyc, err_cnt, irq, s_stb, s_we, s_sel, s_adr, s_wdat}, 128'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      model_err = 0;
      do_txn(32'h3009_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0);
      t = target(32'h3000_0000);
      do_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1 + t, 32'h7777_0000);

      repeat (4) @(negedge clk);
      check("resp_queue_empty", resp_q.size(), 0);
      check("cyc_queue_empty", cyc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
